// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and default word width for piso_tx.
// PARITY exists only when PISO_TX_PARITY_EN is defined.
package piso_pkg;
    localparam int DEFAULT_WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable shift register whose head is the next bit to transmit.
// A load stores the word already advanced by one, since its head bit leaves straight from the input.
module piso_shreg import piso_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             head
);
    logic [WIDTH-1:0] q, src, nxt;
    assign src = load ? d : q;
    assign nxt = MSB_FIRST != 0 ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
    assign head = MSB_FIRST != 0 ? q[WIDTH-1] : q[0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (load || shift) q <= nxt;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter with frame/done strobes.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx import piso_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    state_t state;
    logic [CW-1:0] cnt;
    logic accept, last, head, head_in;
    assign in_ready = state == IDLE || done;
    assign accept = in_valid && in_ready;
    assign last = state == SHIFT && cnt == LAST;
    assign head_in = MSB_FIRST != 0 ? parallel_in[WIDTH-1] : parallel_in[0];
    piso_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk(clk), .rst_n(rst_n), .load(accept), .shift(state == SHIFT), .d(parallel_in), .head(head)
    );
`ifdef PISO_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) par <= 1'b0;
        else if (accept) par <= ^parallel_in;
`endif
    // cnt is the index (1..WIDTH) of the data bit currently on serial_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            serial_out <= 1'b0;
            frame <= 1'b0;
            done <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            cnt <= CW'(1);
            serial_out <= head_in;
            frame <= 1'b1;
            done <= 1'b0;
        end else if (state == SHIFT && !last) begin
            cnt <= cnt + 1'b1;
            serial_out <= head;
`ifdef PISO_TX_PARITY_EN
            done <= 1'b0;
`else
            done <= cnt == LAST - 1'b1;
`endif
`ifdef PISO_TX_PARITY_EN
        end else if (last) begin
            state <= PARITY;
            cnt <= '0;
            serial_out <= par;
            done <= 1'b1;
`endif
        end else begin
            state <= IDLE;
            cnt <= '0;
            serial_out <= 1'b0;
            frame <= 1'b0;
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: random and directed checks of piso_tx (MSB-first and LSB-first) against a bit-queue model.
module tb_piso_tx;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic ready_m, ser_m, frame_m, done_m, ready_l, ser_l, frame_l, done_l;
    int tests = 0, fails = 0;
    bit q_m[$], q_l[$];

    piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(ready_m), .serial_out(ser_m), .frame(frame_m), .done(done_m)
    );
    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(ready_l), .serial_out(ser_l), .frame(frame_l), .done(done_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A frame is just the list of bits in transmit order; the head is what serial_out shows now.
    function automatic void load_frame(input logic [7:0] d);
        q_m.delete();
        q_l.delete();
        for (int i = 7; i >= 0; i--) q_m.push_back(d[i]);
        for (int i = 0; i < 8; i++) q_l.push_back(d[i]);
`ifdef PISO_TX_PARITY_EN
        q_m.push_back(^d);
        q_l.push_back(^d);
`endif
    endfunction

    task automatic compare();
        check("m_ready", ready_m, q_m.size() <= 1);
        check("m_serial", ser_m, q_m.size() > 0 ? q_m[0] : 1'b0);
        check("m_frame", frame_m, q_m.size() > 0);
        check("m_done", done_m, q_m.size() == 1);
        check("l_ready", ready_l, q_l.size() <= 1);
        check("l_serial", ser_l, q_l.size() > 0 ? q_l[0] : 1'b0);
        check("l_frame", frame_l, q_l.size() > 0);
        check("l_done", done_l, q_l.size() == 1);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            q_m.delete();
            q_l.delete();
        end else if (in_valid && q_m.size() <= 1) load_frame(parallel_in);
        else if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        #1 compare();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 q_m.delete();
        q_l.delete();
        compare();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] got_m, got_l, done_mask;
        logic [15:0] dmask;
        #1 compare();
        step();
        rst_n = 1'b1;
        step();
        // 0xA5 in both bit orders; parallel_in is trashed mid-frame
        parallel_in = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got_m = '0;
        got_l = '0;
        done_mask = '0;
        for (int c = 1; c <= 8; c++) begin
            got_m = {got_m[6:0], ser_m};
            got_l = {ser_l, got_l[7:1]};
            done_mask[c-1] = done_m;
            check("ready_low_mid", ready_l, c == 8 && FL == 8);
            if (c == 3) parallel_in = 8'h00;
            if (c < 8) step();
        end
        check("a5_msb_first", got_m, 8'hA5);
        check("a5_lsb_first", got_l, 8'hA5);
        check("a5_done_pos", done_mask, FL == 8 ? 8'h80 : 8'h00);
        step();
        check("a5_tail_done", done_m, FL == 9);
        check("a5_tail_serial", ser_m, FL == 9 ? ^8'hA5 : 1'b0);
        for (int i = 0; i < 3; i++) step();
        // 0x3C then 0xFF back to back with in_valid held
        parallel_in = 8'h3C;
        in_valid = 1'b1;
        step();
        parallel_in = 8'hFF;
        dmask = '0;
        for (int c = 1; c <= 2 * FL; c++) begin
            check("b2b_frame", frame_m, 1);
            dmask[c-1] = done_m;
            if (c == FL + 1) in_valid = 1'b0;
            if (c < 2 * FL) step();
        end
        check("b2b_done_pos", dmask, (16'h1 << (FL - 1)) | (16'h1 << (2 * FL - 1)));
        step();
        check("b2b_end_frame", frame_m, 0);
        step();
        // 0x07: parity bit is 1 when enabled
        parallel_in = 8'h07;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < FL; c++) step();
        check("p07_last_done", done_m, 1);
        check("p07_last_bit", ser_m, 1);
        step();
        // async reset during bit 4 of 0xA5
        parallel_in = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) step();
        async_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            check("post_rst_frame", frame_m, 0);
        end
        // randomized traffic with occasional async resets
        for (int n = 0; n < 600; n++) begin
            in_valid = $urandom_range(0, 3) != 0;
            parallel_in = 8'($urandom);
            if ($urandom_range(0, 79) == 0) async_reset();
            else step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < FL + 2; c++) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
